// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive control path.
package uart_pkg;

    localparam int UART_DIV_W = 16;
    localparam logic [UART_DIV_W-1:0] UART_DIV_DEFAULT = 16'd163;

    typedef enum logic [1:0] {
        DB5 = 2'b00,
        DB6 = 2'b01,
        DB7 = 2'b10,
        DB8 = 2'b11
    } data_bits_e;

    typedef struct packed {
        logic [UART_DIV_W-1:0] div;
        data_bits_e            data_bits;
        logic                  stop_bits;
        logic                  parity_en;
        logic                  parity_type;
    } uart_cfg_t;

    localparam uart_cfg_t UART_CFG_RESET = '{
        div:         UART_DIV_DEFAULT,
        data_bits:   DB8,
        stop_bits:   1'b0,
        parity_en:   1'b0,
        parity_type: 1'b0
    };

    // Mask keeping the low (data_bits+5) bits of a received byte.
    function automatic logic [7:0] data_mask(data_bits_e db);
        return 8'hFF >> (2'd3 - 2'(db));
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO: the head entry is always on
// rd_data. The caller guarantees push only when not full (or popping) and
// pop only when level != 0.
module uart_rx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    cnt;

    // Storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + LW'(1);
                2'b01:   cnt <= cnt - LW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign level   = cnt;
    assign full    = (cnt == LW'(DEPTH));

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: oversample tick, shadow frame config, frame capture
// into a FWFT FIFO, RTS flow control and sticky receive status.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int DEPTH      = 4,
    parameter int RTS_THRESH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_en,
    input  logic                   cfg_wr,
    input  logic [DIV_W-1:0]       cfg_div,
    input  logic [1:0]             cfg_data_bits,
    input  logic                   cfg_stop_bits,
    input  logic                   cfg_parity_en,
    input  logic                   cfg_parity_type,
    output logic                   tick,
    output logic [1:0]             data_bit_num,
    output logic                   stop_bit_num,
    output logic                   parity_en,
    output logic                   parity_type,
    output logic                   rts_n,
    input  logic                   rx_done,
    input  logic [7:0]             rx_data,
    input  logic                   parity_error,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [7:0]             rd_data,
    output logic                   rd_perr,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overrun,
    output logic [7:0]             perr_count,
    input  logic                   clr_status
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    // Read port handshake: rd_valid/rd_data/rd_perr describe the FIFO head;
    // an entry is consumed on any clock edge where rd_valid && rd_ready, and
    // rd_valid never drops without such a transfer (except on reset).

    uart_cfg_t        cfg_q;
    logic [DIV_W-1:0] tick_cnt;
    logic             tick_q;
    logic             rx_done_q;
    logic             cap_v;
    logic [8:0]       cap_w;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             drop;
    logic             perr_ev;
    logic [8:0]       fifo_head;
    logic [LVL_W-1:0] level;
    logic             overrun_q;
    logic [7:0]       perr_q;
    logic             rts_q;

    // Shadow config; writes are honoured only while the receiver is disabled.
    // A divisor wider than the package field is truncated to that field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= UART_CFG_RESET;
        end else if (cfg_wr && !cfg_en) begin
            cfg_q <= '{
                div:         UART_DIV_W'(cfg_div),
                data_bits:   data_bits_e'(cfg_data_bits),
                stop_bits:   cfg_stop_bits,
                parity_en:   cfg_parity_en,
                parity_type: cfg_parity_type
            };
        end
    end

    // Oversample tick: one-cycle strobe every div+1 enabled clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            tick_q   <= 1'b0;
        end else if (!cfg_en) begin
            tick_cnt <= '0;
            tick_q   <= 1'b0;
        end else if (tick_cnt == DIV_W'(cfg_q.div)) begin
            tick_cnt <= '0;
            tick_q   <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + DIV_W'(1);
            tick_q   <= 1'b0;
        end
    end

    // Rising-edge detect on rx_done; the masked frame and its parity flag are
    // captured on the edge and written to the FIFO one clock later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done_q <= 1'b0;
            cap_v     <= 1'b0;
            cap_w     <= '0;
        end else begin
            rx_done_q <= rx_done;
            cap_v     <= cfg_en & rx_done & ~rx_done_q;
            if (rx_done && !rx_done_q) begin
                cap_w <= {parity_error, rx_data & data_mask(cfg_q.data_bits)};
            end
        end
    end

    assign fifo_pop  = rd_valid & rd_ready;
    assign fifo_push = cap_v & (~fifo_full | fifo_pop);
    assign drop      = cap_v & fifo_full & ~fifo_pop;
    assign perr_ev   = cap_v & cap_w[8];

    uart_rx_fifo #(
        .WIDTH (9),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (cap_w),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .level   (level),
        .full    (fifo_full)
    );

    // Sticky status: clear takes effect first, a same-cycle event still lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
            perr_q    <= '0;
        end else if (clr_status) begin
            overrun_q <= drop;
            perr_q    <= perr_ev ? 8'd1 : 8'd0;
        end else begin
            if (drop) overrun_q <= 1'b1;
            if (perr_ev && perr_q != 8'hFF) perr_q <= perr_q + 8'd1;
        end
    end

    // Flow control: stop the sender when disabled or nearly full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rts_q <= 1'b1;
        end else begin
            rts_q <= ~cfg_en | (level >= LVL_W'(RTS_THRESH));
        end
    end

    assign tick         = tick_q;
    assign data_bit_num = cfg_q.data_bits;
    assign stop_bit_num = cfg_q.stop_bits;
    assign parity_en    = cfg_q.parity_en;
    assign parity_type  = cfg_q.parity_type;
    assign rts_n        = rts_q;
    assign rd_valid     = (level != '0);
    assign rd_data      = fifo_head[7:0];
    assign rd_perr      = fifo_head[8];
    assign fifo_level   = level;
    assign overrun      = overrun_q;
    assign perr_count   = perr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl against a queue-based behavioural model.
module tb_uart_rx_ctrl;

    localparam int DIV_W      = 16;
    localparam int DEPTH      = 4;
    localparam int RTS_THRESH = 3;
    localparam int LVL_W      = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic             cfg_en = 0, cfg_wr = 0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic [1:0]       cfg_data_bits = '0;
    logic             cfg_stop_bits = 0, cfg_parity_en = 0, cfg_parity_type = 0;
    logic             rx_done = 0, parity_error = 0, rd_ready = 0, clr_status = 0;
    logic [7:0]       rx_data = '0;

    logic             tick, stop_bit_num, parity_en, parity_type, rts_n;
    logic [1:0]       data_bit_num;
    logic             rd_valid, rd_perr, overrun;
    logic [7:0]       rd_data, perr_count;
    logic [LVL_W-1:0] fifo_level;

    uart_rx_ctrl #(.DIV_W(DIV_W), .DEPTH(DEPTH), .RTS_THRESH(RTS_THRESH)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_wr(cfg_wr), .cfg_div(cfg_div),
        .cfg_data_bits(cfg_data_bits), .cfg_stop_bits(cfg_stop_bits),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_type(cfg_parity_type),
        .tick(tick), .data_bit_num(data_bit_num), .stop_bit_num(stop_bit_num),
        .parity_en(parity_en), .parity_type(parity_type), .rts_n(rts_n),
        .rx_done(rx_done), .rx_data(rx_data), .parity_error(parity_error),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_perr(rd_perr),
        .fifo_level(fifo_level), .overrun(overrun), .perr_count(perr_count),
        .clr_status(clr_status)
    );

    // ---------------- scoreboard / model ----------------
    int n_vec = 0;
    int n_err = 0;
    bit run_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [8:0] exp_q[$];
    int   m_div = 163, m_db = 3;
    bit   m_sb = 0, m_pe = 0, m_pt = 0;
    int   en_cnt = 0, m_perr = 0;
    bit   m_tick = 0, m_rts = 1, m_ovr = 0, m_done_q = 0, pend_v = 0, pop_m = 0;
    logic [8:0] pend_w = '0;

    task automatic m_reset();
        exp_q.delete();
        m_div = 163; m_db = 3; m_sb = 0; m_pe = 0; m_pt = 0;
        en_cnt = 0; m_perr = 0; m_tick = 0; m_rts = 1; m_ovr = 0;
        m_done_q = 0; pend_v = 0; pend_w = '0;
    endtask

    // Model: each clock applies the frame-level rules to the expected queue.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reset();
        end else begin
            if (!cfg_en) begin
                en_cnt = 0;
                m_tick = 0;
            end else begin
                en_cnt++;
                m_tick = (en_cnt % (m_div + 1)) == 0;
            end
            m_rts = !cfg_en || (exp_q.size() >= RTS_THRESH);
            pop_m = (exp_q.size() != 0) && rd_ready;
            if (pop_m) void'(exp_q.pop_front());
            if (clr_status) begin
                m_ovr  = 0;
                m_perr = 0;
            end
            if (pend_v) begin
                if (pend_w[8]) m_perr = (m_perr == 255) ? 255 : m_perr + 1;
                if (exp_q.size() < DEPTH) exp_q.push_back(pend_w);
                else m_ovr = 1;
            end
            pend_v   = cfg_en && rx_done && !m_done_q;
            if (pend_v) pend_w = {parity_error, rx_data & 8'((1 << (m_db + 5)) - 1)};
            m_done_q = rx_done;
            if (cfg_wr && !cfg_en) begin
                m_div = int'(cfg_div); m_db = int'(cfg_data_bits);
                m_sb = cfg_stop_bits; m_pe = cfg_parity_en; m_pt = cfg_parity_type;
            end
        end
    end

    // Compare process: every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (run_chk) begin
            check("tick", tick, m_tick);
            check("rts_n", rts_n, m_rts);
            check("rd_valid", rd_valid, exp_q.size() != 0);
            check("fifo_level", fifo_level, exp_q.size());
            check("overrun", overrun, m_ovr);
            check("perr_count", perr_count, m_perr);
            check("data_bit_num", data_bit_num, m_db);
            check("stop_bit_num", stop_bit_num, m_sb);
            check("parity_en", parity_en, m_pe);
            check("parity_type", parity_type, m_pt);
            if (exp_q.size() != 0) begin
                check("rd_data", rd_data, exp_q[0][7:0]);
                check("rd_perr", rd_perr, exp_q[0][8]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [7:0] d, input logic pe, input int hold);
        @(negedge clk);
        rx_done = 1; rx_data = d; parity_error = pe;
        repeat (hold) @(negedge clk);
        rx_done = 0; rx_data = 8'($urandom); parity_error = 0;
        @(negedge clk);
    endtask

    task automatic set_cfg(input int div, input int db, input bit sb, input bit pe, input bit pt);
        @(negedge clk);
        cfg_wr = 1; cfg_div = DIV_W'(div); cfg_data_bits = 2'(db);
        cfg_stop_bits = sb; cfg_parity_en = pe; cfg_parity_type = pt;
        @(negedge clk);
        cfg_wr = 0;
    endtask

    task automatic pop_one();
        @(negedge clk); rd_ready = 1;
        @(negedge clk); rd_ready = 0;
    endtask

    task automatic measure_period(output int p);
        int t0;
        t0 = -1; p = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tick) begin
                if (t0 < 0) t0 = i;
                else begin p = i - t0; break; end
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tick"}, tick, 0);
        check({tag, "_rts_n"}, rts_n, 1);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_perr"}, rd_perr, 0);
        check({tag, "_level"}, fifo_level, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_perr_count"}, perr_count, 0);
        check({tag, "_data_bits"}, data_bit_num, 2'b11);
        check({tag, "_stop"}, stop_bit_num, 0);
        check({tag, "_par_en"}, parity_en, 0);
        check({tag, "_par_type"}, parity_type, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1;
        run_chk = 1;

        // Tick period at the default divisor, then an ignored write while enabled.
        @(negedge clk); cfg_en = 1;
        measure_period(p); check("tick_period_164", p, 164);
        set_cfg(3, 0, 1, 1, 1);
        check("cfg_ignored_db", data_bit_num, 2'b11);
        check("cfg_ignored_stop", stop_bit_num, 0);
        measure_period(p); check("tick_period_still_164", p, 164);
        @(negedge clk); cfg_en = 0;
        set_cfg(3, 0, 0, 0, 0);
        @(negedge clk); cfg_en = 1;
        measure_period(p); check("tick_period_4", p, 4);

        // Masking with 5 data bits, then 8 data bits.
        send_frame(8'hFB, 0, 1);
        check("mask5_valid", rd_valid, 1);
        check("mask5_data", rd_data, 8'h1B);
        pop_one();
        @(negedge clk); cfg_en = 0;
        set_cfg(3, 3, 0, 0, 0);
        @(negedge clk); cfg_en = 1;
        send_frame(8'hA5, 0, 1);
        check("mask8_data", rd_data, 8'hA5);
        pop_one();

        // rx_done held high is one frame.
        send_frame(8'h3C, 0, 10);
        check("held_level", fifo_level, 1);
        pop_one();

        // Flow control.
        for (int i = 0; i < 3; i++) send_frame(8'(i + 1), 0, 1);
        check("rts_lag", rts_n, 0);
        @(negedge clk);
        check("rts_at_thresh", rts_n, 1);
        pop_one();
        @(negedge clk);
        check("rts_after_pop", rts_n, 0);
        pop_one(); pop_one();

        // Overrun: 5 frames into a 4-deep FIFO.
        for (int i = 0; i < 5; i++) send_frame(8'(8'h10 + i), 0, 1);
        check("ovr_level", fifo_level, 4);
        check("ovr_flag", overrun, 1);
        for (int i = 0; i < 4; i++) begin
            check("ovr_order", rd_data, 8'(8'h10 + i));
            pop_one();
        end
        @(negedge clk); clr_status = 1;
        @(negedge clk); clr_status = 0;
        check("ovr_cleared", overrun, 0);

        // Push and pop in the same cycle while full.
        for (int i = 0; i < 4; i++) send_frame(8'(8'h20 + i), 0, 1);
        @(negedge clk); rx_done = 1; rx_data = 8'h55;
        @(negedge clk); rx_done = 0; rd_ready = 1;
        @(negedge clk); rd_ready = 0;
        check("full_pp_level", fifo_level, 4);
        check("full_pp_ovr", overrun, 0);
        check("full_pp_head", rd_data, 8'h21);
        repeat (4) pop_one();

        // Parity error saturation, then clear coincident with an error frame.
        rd_ready = 1;
        repeat (300) send_frame(8'($urandom), 1, 1);
        rd_ready = 0;
        check("perr_sat", perr_count, 255);
        @(negedge clk); rx_done = 1; parity_error = 1; clr_status = 1; rx_data = 8'h77;
        @(negedge clk); rx_done = 0; parity_error = 0; clr_status = 0;
        @(negedge clk);
        check("perr_clr_same", perr_count, 1);
        pop_one();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rx_done      = ($urandom_range(0, 3) == 0);
            rx_data      = 8'($urandom);
            parity_error = 1'($urandom);
            rd_ready     = ($urandom_range(0, 2) == 0);
            clr_status   = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 199) == 0) cfg_en = ~cfg_en;
            cfg_wr          = ($urandom_range(0, 15) == 0);
            cfg_div         = DIV_W'($urandom_range(0, 5));
            cfg_data_bits   = 2'($urandom);
            cfg_stop_bits   = 1'($urandom);
            cfg_parity_en   = 1'($urandom);
            cfg_parity_type = 1'($urandom);
        end
        @(negedge clk);
        rx_done = 0; rd_ready = 0; clr_status = 0; cfg_wr = 0; cfg_en = 1;

        // Asynchronous reset with frames buffered.
        send_frame(8'h5A, 1, 1);
        send_frame(8'hC3, 0, 1);
        #2 rst_n = 0;
        #1 check_reset_values("async_reset");
        cfg_en = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk); cfg_en = 1;
        send_frame(8'h99, 0, 1);
        check("post_reset_data", rd_data, 8'h99);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Control and buffering block for the UART receive path; sits between the register/config interface and `uart_rx`. Generates the 16x-oversampling `tick`, holds frame configuration in shadow registers, captures each received frame (data plus parity flag) into a small first-word-fall-through (FWFT) FIFO, and drives `rts_n` flow control from FIFO occupancy. Exposes a valid/ready read port and sticky status to the consumer.

## Interface
- `DIV_W`, 16, width of baud divisor
- `DEPTH`, 4, FIFO entries (power of 2, ≥2)
- `RTS_THRESH`, 3, occupancy at/above which `rts_n` deasserts (1 ≤ RTS_THRESH ≤ DEPTH)

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous reset, active-low
- `cfg_en`  in  1  receiver enable
- `cfg_wr`  in  1  load cfg_* into shadow registers (honoured only when `cfg_en`=0)
- `cfg_div`  in  DIV_W  tick period minus 1, in clocks
- `cfg_data_bits`  in  2  data bits minus 5
- `cfg_stop_bits`  in  1  0=1 stop, 1=2 stop
- `cfg_parity_en`  in  1  parity enable
- `cfg_parity_type`  in  1  0=even, 1=odd
- `tick`  out  1  one-cycle oversample strobe to `uart_rx`
- `data_bit_num`  out  2, `stop_bit_num` out 1, `parity_en` out 1, `parity_type` out 1: shadow config to `uart_rx`
- `rts_n`  out  1  to `uart_rx.rts_n`; 0 = ready to receive
- `rx_done`  in  1  from `uart_rx`; frame complete (level or pulse)
- `rx_data`  in  8  from `uart_rx`
- `parity_error`  in  1  from `uart_rx`
- `rd_valid`  out  1, `rd_ready` in 1: consumer handshake
- `rd_data`  out  8, `rd_perr` out 1: FIFO head
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy
- `overrun`  out  1  sticky: frame dropped because FIFO full
- `perr_count`  out  8  saturating count of frames with parity error
- `clr_status`  in  1  clears `overrun`, `perr_count`

## Operation
- Shadow config reset: div=163, data_bits=2'b11 (8), stop=0, parity_en=0, parity_type=0. `cfg_wr` with `cfg_en`=1 is ignored entirely.
- Tick generator: counter held at 0 and `tick`=0 while `cfg_en`=0. While enabled, counter increments each clock; when counter==div it wraps to 0 and `tick` is registered high for one cycle. Period = div+1 clocks; div=0 yields `tick` every cycle.
- Capture: `rx_done` registered (`rx_done_q`); a push occurs on `rx_done & ~rx_done_q` while `cfg_en`=1. Pushed data = `rx_data` with bits at index ≥ data_bits+5 forced to 0; `rd_perr` = `parity_error` sampled in the same cycle.
- FIFO: FWFT; `rd_valid`=(level≠0). Pop on `rd_valid & rd_ready`. When full, a push is accepted only if a pop occurs in the same cycle; otherwise the frame is dropped and `overrun` is set. Simultaneous push and pop on a non-empty FIFO leaves level unchanged. Pointers wrap modulo DEPTH.
- `rts_n` (registered) = 1 if `cfg_en`=0 or level ≥ RTS_THRESH, else 0.
- `perr_count` increments on every push event with `parity_error`=1, dropped or not; saturates at 255.
- `clr_status`: clears first; an event in the same cycle is still counted (`overrun`=1 / count=1).
- `cfg_en` falling: tick stops and captures are ignored; FIFO contents and status are retained.

## Timing
- Reset values: `tick`=0, `rts_n`=1, `rd_valid`=0, `rd_data`=0, `rd_perr`=0, `fifo_level`=0, `overrun`=0, `perr_count`=0, config outputs at the shadow defaults.
- First `tick` occurs div+1 clocks after the first enabled edge.
- Capture latency: `rx_done` first sampled high at edge k → `rd_valid`/`rd_data` valid after edge k+1 (edge-detect register plus write).
- Pop latency: next head is visible the cycle after the accepting edge.
- `rts_n` follows level with one cycle of lag.
- Config outputs change one clock after an accepted `cfg_wr`.
- Asynchronous reset mid-frame or mid-handshake returns every output to its reset value immediately and discards FIFO contents.

## Structure
- Package `uart_pkg`:
  - `data_bits_e` (DB5..DB8 = 2'b00..2'b11)
  - `uart_cfg_t` struct (div, data_bits, stop_bits, parity_en, parity_type)
  - `UART_DIV_DEFAULT`=163
  - `uart_cfg_t` reset constant
- Sub-module `uart_rx_fifo`: synchronous FWFT FIFO, width 9, DEPTH, with level output.
- Tick generator, shadow registers, edge detect, status, and RTS logic live in `uart_rx_ctrl`.

## Test plan
- Tick period: div=163, cfg_en=1 → `tick` pulses exactly every 164 clocks. Reprogram div=3 with cfg_en=1 → ignored; after cfg_en=0, cfg_wr, cfg_en=1 → period 4.
- Masking: data_bits=2'b00, `rx_data`=8'hFB, `rx_done` pulse → `rd_data`=8'h1B. With data_bits=2'b11 and 8'hA5 → 8'hA5.
- Held level: `rx_done` held high for 10 cycles → exactly one push; `fifo_level`=1, `rd_valid` after one clock.
- Flow control: 3 frames with no reads → `rts_n`=1 the cycle after level reaches 3. One pop → `rts_n`=0.
- Overrun: 5 frames with `rd_ready`=0, DEPTH=4 → level=4, `overrun`=1, and pops return frames 1–4 in order. Push and pop in the same cycle while full → no overrun, level stays 4.
- Parity status: 300 frames with `parity_error`=1 → `perr_count`=255. `clr_status` coincident with a parity-error frame → `perr_count`=1. Asynchronous reset mid-stream → all outputs at reset values.
